// File: rtl/nanov_mem_pkg.sv
// Shared types and constants for the nanoV SPI memory controller.
// Holds the controller state encoding, default SPI opcodes and request length codes.
package nanov_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_CS_GAP,
        ST_CMD,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    localparam logic [1:0] LEN_1B     = 2'd0;
    localparam logic [1:0] LEN_2B     = 2'd1;
    localparam logic [1:0] LEN_4B_ALT = 2'd2;
    localparam logic [1:0] LEN_4B     = 2'd3;

    // The spare length code is folded onto a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        len_bytes = 3'd4;
        case (len)
            LEN_1B:             len_bytes = 3'd1;
            LEN_2B:             len_bytes = 3'd2;
            LEN_4B_ALT, LEN_4B: len_bytes = 3'd4;
            default:            len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/nanov_spi_shift.sv
// SPI mode-0 bit engine: two clk cycles per bit, MSB-first out of a 32-bit register.
// A load starts a segment of load_cnt_i+1 bits; done_o marks the edge that finishes it.
module nanov_spi_shift (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_i,
    input  logic [31:0] load_dat_i,
    input  logic [4:0]  load_cnt_i,
    input  logic        miso_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [31:0] rx_o
);

    logic        active_q;
    logic        phase_q;
    logic [4:0]  cnt_q;
    logic [31:0] sr_q;
    logic        miso_q;

    // rx_o is the register content after the pending shift, so the owner can
    // capture a complete received word on the done edge itself.
    assign rx_o   = {sr_q[30:0], miso_q};
    assign done_o = active_q & phase_q & (cnt_q == 5'd0);
    assign sck_o  = phase_q;
    assign mosi_o = active_q & sr_q[31];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= 5'd0;
            sr_q     <= 32'd0;
            miso_q   <= 1'b0;
        end else if (load_i) begin
            active_q <= 1'b1;
            phase_q  <= 1'b0;
            cnt_q    <= load_cnt_i;
            sr_q     <= load_dat_i;
        end else if (active_q) begin
            if (!phase_q) begin
                phase_q <= 1'b1;
                miso_q  <= miso_i;
            end else begin
                phase_q <= 1'b0;
                sr_q    <= rx_o;
                if (cnt_q == 5'd0) begin
                    active_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/nanov_spi_mem_ctrl.sv
// Services nanoV read/write requests on a 23LC-style SPI memory; sequential reads stream.
// Latency 2 clk per SPI bit (+2 for a CS gap); req_ready only while idle or streaming.
module nanov_spi_mem_ctrl
    import nanov_mem_pkg::*;
#(
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
    parameter bit         STREAM_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_len,
    input  logic [31:0]          req_wdata,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    output logic                 wr_done,
    output logic                 spi_cs_n,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    state_t               state_q;
    logic                 cs_n_q;
    logic                 rd_valid_q;
    logic                 wr_done_q;
    logic [31:0]          rd_data_q;
    logic                 stream_vld_q;
    logic [ADDR_BITS-1:0] next_addr_q;
    logic                 write_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [2:0]           bytes_q;
    logic [31:0]          wdata_q;
    logic                 gap_q;

    logic        accept;
    logic        seq_hit;
    logic        ld_d;
    logic [31:0] ld_dat_d;
    logic [4:0]  ld_cnt_d;
    logic        sh_done;
    logic [31:0] sh_rx;

    function automatic logic [4:0] data_cnt(input logic [2:0] b);
        case (b)
            3'd1:    return 5'd7;
            3'd2:    return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    // The first byte on the wire lands in the most significant received bits.
    function automatic logic [31:0] rx_word(input logic [31:0] rx, input logic [2:0] b);
        case (b)
            3'd1:    return {24'd0, rx[7:0]};
            3'd2:    return {16'd0, rx[7:0], rx[15:8]};
            default: return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign accept    = req_valid && req_ready;
    assign seq_hit   = stream_vld_q && !req_write && (req_addr == next_addr_q);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_done   = wr_done_q;
    assign spi_cs_n  = cs_n_q;

    always_comb begin
        ld_d     = 1'b0;
        ld_dat_d = 32'd0;
        ld_cnt_d = 5'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ld_d     = 1'b1;
                    ld_dat_d = {(req_write ? CMD_WRITE : CMD_READ), 24'd0};
                    ld_cnt_d = 5'd7;
                end
            end
            ST_STREAM: begin
                if (accept && seq_hit) begin
                    ld_d     = 1'b1;
                    ld_cnt_d = data_cnt(len_bytes(req_len));
                end
            end
            ST_CS_GAP: begin
                if (gap_q) begin
                    ld_d     = 1'b1;
                    ld_dat_d = {(write_q ? CMD_WRITE : CMD_READ), 24'd0};
                    ld_cnt_d = 5'd7;
                end
            end
            ST_CMD: begin
                if (sh_done) begin
                    ld_d     = 1'b1;
                    ld_dat_d = 32'(addr_q) << (32 - ADDR_BITS);
                    ld_cnt_d = 5'(ADDR_BITS - 1);
                end
            end
            ST_ADDR: begin
                if (sh_done) begin
                    ld_d     = 1'b1;
                    ld_dat_d = write_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                                       : 32'd0;
                    ld_cnt_d = data_cnt(bytes_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cs_n_q       <= 1'b1;
            rd_valid_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            rd_data_q    <= 32'd0;
            stream_vld_q <= 1'b0;
            next_addr_q  <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            bytes_q      <= 3'd1;
            wdata_q      <= 32'd0;
            gap_q        <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                bytes_q <= len_bytes(req_len);
                wdata_q <= req_wdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cs_n_q  <= 1'b0;
                        state_q <= ST_CMD;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (seq_hit) begin
                            state_q <= ST_DATA;
                        end else begin
                            cs_n_q       <= 1'b1;
                            gap_q        <= 1'b0;
                            stream_vld_q <= 1'b0;
                            state_q      <= ST_CS_GAP;
                        end
                    end
                end
                ST_CS_GAP: begin
                    if (gap_q) begin
                        cs_n_q  <= 1'b0;
                        state_q <= ST_CMD;
                    end else begin
                        gap_q <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sh_done) state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (sh_done) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (sh_done) begin
                        if (write_q) begin
                            wr_done_q    <= 1'b1;
                            cs_n_q       <= 1'b1;
                            stream_vld_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= rx_word(sh_rx, bytes_q);
                            if (STREAM_EN) begin
                                stream_vld_q <= 1'b1;
                                next_addr_q  <= addr_q + ADDR_BITS'(bytes_q);
                                state_q      <= ST_STREAM;
                            end else begin
                                cs_n_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    nanov_spi_shift u_shift (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (ld_d),
        .load_dat_i (ld_dat_d),
        .load_cnt_i (ld_cnt_d),
        .miso_i     (spi_miso),
        .sck_o      (spi_sck),
        .mosi_o     (spi_mosi),
        .done_o     (sh_done),
        .rx_o       (sh_rx)
    );

endmodule
